dplca_nodeid_ctrl: RTL and testbench

DPLCA_NODEID_CTRL -- requirements
Module: dplca_nodeid_ctrl

---
 rtl/dplca_nodeid_ctrl_pkg.sv | 25 ++
 rtl/dplca_txop_table.sv | 80 ++++++++
 rtl/dplca_nodeid_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dplca_nodeid_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dplca_nodeid_ctrl_pkg.sv
// Shared encodings for the DPLCA node-ID controller: claim codes, aging codes,
// FSM state codes and the unassigned node ID.
package dplca_nodeid_ctrl_pkg;

  localparam logic [1:0] CLAIM_NONE = 2'b00;
  localparam logic [1:0] CLAIM_SOFT = 2'b01;
  localparam logic [1:0] CLAIM_HARD = 2'b10;

  localparam logic AGING_OFF = 1'b0;
  localparam logic AGING_ON  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_UPDATE = 2'd3
  } ctrl_state_t;

  localparam logic [7:0] NODEID_UNASSIGNED = 8'd255;

  function automatic logic is_claim(input logic [1:0] claim);
    return (claim == CLAIM_SOFT) || (claim == CLAIM_HARD);
  endfunction

endpackage

// File: rtl/dplca_txop_table.sv
// 256-entry TXOP claim table (seen/claimed/age) with the per-index scan update.
// Age storage exists only when DPLCA_AGING_EN is defined.
module dplca_txop_table
  import dplca_nodeid_ctrl_pkg::*;
#(
  parameter int unsigned AGING_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_cap_en,
  input  logic [7:0] i_cap_id,
  input  logic       i_scan_en,
  input  logic [7:0] i_scan_idx,
  output logic       o_scan_claimed
);

  if ((AGING_CYCLES < 1) || (AGING_CYCLES > 3)) begin : g_bad_aging_cycles
    $error("dplca_txop_table: AGING_CYCLES must be in 1..3");
  end

  logic [255:0] r_seen;
  logic [255:0] r_claimed;
  logic         w_new_claimed;

`ifdef DPLCA_AGING_EN
  localparam logic [1:0] AGE_INIT = 2'(AGING_CYCLES);

  logic [255:0][1:0] r_age;
  logic [1:0]        w_cur_age;
  logic [1:0]        w_new_age;

  always_comb begin
    w_cur_age     = r_age[i_scan_idx];
    w_new_age     = w_cur_age;
    w_new_claimed = r_claimed[i_scan_idx];
    if (r_seen[i_scan_idx]) begin
      w_new_age     = AGE_INIT;
      w_new_claimed = 1'b1;
    end else if (w_cur_age != 2'd0) begin
      w_new_age     = w_cur_age - 2'd1;
      w_new_claimed = (w_cur_age != 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_age <= '0;
    end else if (i_scan_en) begin
      r_age[i_scan_idx] <= w_new_age;
    end
  end
`else
  // Without aging a claim is sticky until the table is cleared.
  always_comb begin
    w_new_claimed = r_claimed[i_scan_idx] | r_seen[i_scan_idx];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_claimed <= '0;
    end else if (i_scan_en) begin
      r_claimed[i_scan_idx] <= w_new_claimed;
    end
  end

  // The capture assignment comes last so it wins over the scan clear.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_seen <= '0;
    end else begin
      if (i_scan_en) r_seen[i_scan_idx] <= 1'b0;
      if (i_cap_en)  r_seen[i_cap_id]   <= 1'b1;
    end
  end

  assign o_scan_claimed = w_new_claimed;

endmodule

// File: rtl/dplca_nodeid_ctrl.sv
// DPLCA node-ID allocation controller: captures TXOP claims, scans the table
// once per PLCA cycle and allocates the local ID. Optional aging: DPLCA_AGING_EN.
//
// state  | meaning
// IDLE   | waiting for cycle_start
// SCAN   | one table entry per clock, index 0..255, tracks max claimed / min free
// DECIDE | allocate local ID, compute node count
// UPDATE | one-clock table-update pulse
module dplca_nodeid_ctrl
  import dplca_nodeid_ctrl_pkg::*;
#(
  parameter int unsigned DPLCA_AGING_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dplca_en,
  input  logic       cycle_start,
  input  logic [1:0] dplca_txop_claim,
  input  logic       dplca_txop_end,
  input  logic [7:0] dplca_txop_id,
  output logic [7:0] local_nodeID,
  output logic [7:0] plca_node_count,
  output logic       dplca_txop_table_upd,
  output logic       dplca_aging,
  output logic [1:0] ctrl_state
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;

  logic [7:0] r_idx;
  logic       r_end_d;
  logic       r_have_claimed;
  logic [7:0] r_max_claimed;
  logic [7:0] r_min_free;
  logic [7:0] r_local;
  logic [7:0] r_count;

  logic       w_cap;
  logic       w_scan_en;
  logic       w_scan_claimed;
  logic       w_upd;
  logic [7:0] w_local_nxt;
  logic [7:0] w_count_nxt;
  logic [7:0] w_hi;
  logic       w_any;
  logic [8:0] w_sum;

  assign w_cap = dplca_en && dplca_txop_end && !r_end_d && is_claim(dplca_txop_claim);

  dplca_txop_table #(
    .AGING_CYCLES(DPLCA_AGING_CYCLES)
  ) u_table (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (!dplca_en),
    .i_cap_en      (w_cap),
    .i_cap_id      (dplca_txop_id),
    .i_scan_en     (w_scan_en),
    .i_scan_idx    (r_idx),
    .o_scan_claimed(w_scan_claimed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scan_en   = 1'b0;
    w_upd       = 1'b0;
    if (!dplca_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (cycle_start) w_state_nxt = ST_SCAN;
        ST_SCAN: begin
          w_scan_en = 1'b1;
          if (r_idx == 8'd255) w_state_nxt = ST_DECIDE;
        end
        ST_DECIDE: w_state_nxt = ST_UPDATE;
        ST_UPDATE: begin
          w_upd       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // A newly allocated local ID already counts toward this cycle's node count.
  always_comb begin
    w_local_nxt = r_local;
    if ((r_local == NODEID_UNASSIGNED) && (r_min_free != NODEID_UNASSIGNED)) begin
      w_local_nxt = r_min_free;
    end
    w_hi  = r_have_claimed ? r_max_claimed : 8'd0;
    w_any = r_have_claimed;
    if (w_local_nxt != NODEID_UNASSIGNED) begin
      w_any = 1'b1;
      if (w_local_nxt > w_hi) w_hi = w_local_nxt;
    end
    w_sum       = {1'b0, w_hi} + 9'd1;
    w_count_nxt = !w_any ? 8'd0 : (w_sum[8] ? 8'd255 : w_sum[7:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_end_d <= 1'b0;
    end else begin
      r_end_d <= dplca_txop_end;
    end
  end

  // r_min_free == 255 doubles as "no free ID found yet".
  always_ff @(posedge clk) begin
    if (reset || !dplca_en) begin
      r_idx          <= 8'd0;
      r_have_claimed <= 1'b0;
      r_max_claimed  <= 8'd0;
      r_min_free     <= NODEID_UNASSIGNED;
      r_local        <= NODEID_UNASSIGNED;
      r_count        <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cycle_start) begin
            r_idx          <= 8'd0;
            r_have_claimed <= 1'b0;
            r_max_claimed  <= 8'd0;
            r_min_free     <= NODEID_UNASSIGNED;
          end
        end
        ST_SCAN: begin
          r_idx <= r_idx + 8'd1;
          if (w_scan_claimed) begin
            r_have_claimed <= 1'b1;
            r_max_claimed  <= r_idx;
          end else if ((r_min_free == NODEID_UNASSIGNED) && (r_idx != 8'd0) &&
                       (r_idx != 8'd255)) begin
            r_min_free <= r_idx;
          end
        end
        ST_DECIDE: begin
          r_local <= w_local_nxt;
          r_count <= w_count_nxt;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DPLCA_AGING_EN
  logic r_aging;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aging <= AGING_OFF;
    end else begin
      r_aging <= dplca_en ? AGING_ON : AGING_OFF;
    end
  end

  assign dplca_aging = r_aging;
`else
  assign dplca_aging = AGING_OFF;
`endif

  assign local_nodeID         = r_local;
  assign plca_node_count      = r_count;
  assign dplca_txop_table_upd = w_upd;
  assign ctrl_state           = r_state;

endmodule

// File: tb/tb_dplca_nodeid_ctrl.sv
// Self-checking bench for dplca_nodeid_ctrl: event-level model plus directed scenarios.
module tb_dplca_nodeid_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dplca_en = 1'b1;
  logic       cycle_start = 1'b0;
  logic [1:0] dplca_txop_claim = 2'b00;
  logic       dplca_txop_end = 1'b0;
  logic [7:0] dplca_txop_id = 8'd0;
  logic [7:0] local_nodeID;
  logic [7:0] plca_node_count;
  logic       dplca_txop_table_upd;
  logic       dplca_aging;
  logic [1:0] ctrl_state;

  int total = 0;
  int bad   = 0;

`ifdef DPLCA_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif
  localparam int N_AGE = 3;

  always #5 clk = ~clk;

  dplca_nodeid_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .dplca_en            (dplca_en),
    .cycle_start         (cycle_start),
    .dplca_txop_claim    (dplca_txop_claim),
    .dplca_txop_end      (dplca_txop_end),
    .dplca_txop_id       (dplca_txop_id),
    .local_nodeID        (local_nodeID),
    .plca_node_count     (plca_node_count),
    .dplca_txop_table_upd(dplca_txop_table_upd),
    .dplca_aging         (dplca_aging),
    .ctrl_state          (ctrl_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: captures are timestamped events; the whole table is resolved at the
  // decide edge. Entry i is read by the scan at edge start+1+i, so a capture
  // counts in this cycle only if it happened strictly before that edge.
  int cyc = 0;
  int m_start = -1;
  int pend_id[$];
  int pend_t[$];
  int m_age[256];
  bit m_claimed[256];
  int m_local = 255;
  int m_count = 0;
  bit m_aging = 1'b0;
  bit m_prev_end = 1'b0;
  bit m_valid = 1'b0;

  function automatic void m_clear();
    for (int i = 0; i < 256; i++) begin
      m_age[i] = 0;
      m_claimed[i] = 1'b0;
    end
    pend_id.delete();
    pend_t.delete();
    m_start = -1;
    m_local = 255;
    m_count = 0;
  endfunction

  function automatic void m_decide();
    bit s[256];
    int hi;
    int free;
    for (int i = 0; i < 256; i++) s[i] = 1'b0;
    for (int j = pend_id.size() - 1; j >= 0; j--) begin
      if (pend_t[j] < m_start + 1 + pend_id[j]) begin
        s[pend_id[j]] = 1'b1;
        pend_id.delete(j);
        pend_t.delete(j);
      end
    end
    hi = -1;
    free = -1;
    for (int i = 0; i < 256; i++) begin
      if (AGING) begin
        if (s[i]) m_age[i] = N_AGE;
        else if (m_age[i] > 0) m_age[i] = m_age[i] - 1;
        m_claimed[i] = (m_age[i] > 0);
      end else if (s[i]) begin
        m_claimed[i] = 1'b1;
      end
      if (m_claimed[i]) hi = i;
      else if (free < 0 && i >= 1 && i <= 254) free = i;
    end
    if (m_local == 255 && free >= 0) m_local = free;
    if (m_local != 255 && m_local > hi) hi = m_local;
    m_count = (hi < 0) ? 0 : ((hi + 1 > 255) ? 255 : hi + 1);
  endfunction

  function automatic int m_state();
    int d;
    if (m_start < 0) return 0;
    d = cyc - m_start;
    if (d <= 255) return 1;
    if (d == 256) return 2;
    if (d == 257) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_valid = 1'b1;
    if (reset) begin
      m_clear();
      m_prev_end = 1'b0;
      m_aging = 1'b0;
    end else if (!dplca_en) begin
      m_clear();
      m_prev_end = dplca_txop_end;
      m_aging = 1'b0;
    end else begin
      if (dplca_txop_end && !m_prev_end &&
          (dplca_txop_claim == 2'b01 || dplca_txop_claim == 2'b10)) begin
        pend_id.push_back(int'(dplca_txop_id));
        pend_t.push_back(cyc);
      end
      m_prev_end = dplca_txop_end;
      m_aging = AGING;
      if (m_start >= 0 && cyc == m_start + 257) m_decide();
      if (cycle_start && (m_start < 0 || cyc >= m_start + 259)) m_start = cyc;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("upd", dplca_txop_table_upd, (m_start >= 0 && cyc == m_start + 257));
      check("state", ctrl_state, m_state());
      check("local", local_nodeID, m_local);
      check("count", plca_node_count, m_count);
      check("aging", dplca_aging, m_aging);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic claim(input int id, input logic [1:0] c);
    @(negedge clk);
    dplca_txop_id = 8'(id);
    dplca_txop_claim = c;
    dplca_txop_end = 1'b1;
    @(negedge clk);
    dplca_txop_end = 1'b0;
    dplca_txop_claim = 2'b00;
  endtask

  task automatic start_cycle(output int k);
    @(negedge clk);
    cycle_start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    cycle_start = 1'b0;
  endtask

  task automatic wait_upd(input string name, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dplca_txop_table_upd === 1'b1) begin
        at = cyc + 1;
        break;
      end
    end
    check({name, "_timeout"}, (at >= 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int at;
    int n_upd;
    int exp_cnt[4];

    // Reset with enable held high: reset must dominate.
    tick(3);
    reset = 1'b0;
    do_reset();
    check("rst_state", ctrl_state, 0);
    check("rst_local", local_nodeID, 255);
    check("rst_count", plca_node_count, 0);
    check("rst_upd", dplca_txop_table_upd, 0);
    check("rst_aging", dplca_aging, 0);

    // Basic allocation; a NONE claim at ID 6 must be ignored.
    claim(1, 2'b01);
    claim(2, 2'b01);
    claim(4, 2'b10);
    claim(6, 2'b00);
    start_cycle(k);
    wait_upd("s1", at);
    check("s1_latency", at - k, 258);
    check("s1_local", local_nodeID, 3);
    check("s1_count", plca_node_count, 5);
    check("s1_aging", dplca_aging, AGING);
    @(negedge clk);
    check("s1_upd_one_clock", dplca_txop_table_upd, 0);

    // Aging / no-aging: ID 5 claimed once, then three cycles without claims.
    do_reset();
    if (AGING) exp_cnt = '{6, 6, 6, 2};
    else       exp_cnt = '{6, 6, 6, 6};
    claim(5, 2'b01);
    for (int c = 0; c < 4; c++) begin
      start_cycle(k);
      wait_upd("s2", at);
      check($sformatf("s2_count_%0d", c), plca_node_count, exp_cnt[c]);
      check($sformatf("s2_local_%0d", c), local_nodeID, 1);
      check($sformatf("s2_aging_%0d", c), dplca_aging, AGING);
    end

    // Collision: capture of ID 7 on the very edge the scan processes index 7.
    do_reset();
    start_cycle(k);
    tick(6);
    claim(7, 2'b01);
    wait_upd("s3a", at);
    check("s3_first_count", plca_node_count, 2);
    check("s3_first_local", local_nodeID, 1);
    start_cycle(k);
    wait_upd("s3b", at);
    check("s3_second_count", plca_node_count, 8);

    // Full table: no free ID left.
    do_reset();
    for (int id = 1; id <= 254; id++) claim(id, (id % 2) ? 2'b01 : 2'b10);
    start_cycle(k);
    wait_upd("s4", at);
    check("s4_local", local_nodeID, 255);
    check("s4_count", plca_node_count, 255);

    // Disable mid-scan at index 100, then re-sync with a stray cycle_start.
    do_reset();
    claim(3, 2'b01);
    start_cycle(k);
    wait_upd("s5a", at);
    check("s5_local_before", local_nodeID, 1);
    check("s5_count_before", plca_node_count, 4);
    start_cycle(k);
    tick(99);
    check("s5_in_scan", ctrl_state, 1);
    @(negedge clk);
    dplca_en = 1'b0;
    @(negedge clk);
    check("s5_dis_state", ctrl_state, 0);
    check("s5_dis_local", local_nodeID, 255);
    check("s5_dis_count", plca_node_count, 0);
    claim(9, 2'b10);
    start_cycle(k);
    tick(2);
    dplca_en = 1'b1;
    tick(2);
    check("s5_idle_after_en", ctrl_state, 0);
    claim(3, 2'b01);
    start_cycle(k);
    tick(50);
    cycle_start = 1'b1;
    @(negedge clk);
    cycle_start = 1'b0;
    n_upd = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (dplca_txop_table_upd === 1'b1) n_upd++;
    end
    check("s5_single_upd", n_upd, 1);
    check("s5_resync_local", local_nodeID, 1);
    check("s5_resync_count", plca_node_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
